// File: rtl/if_stage.sv
// MIPS fetch stage: PC register, next-PC select, IF/ID register and stall/flush counters.
// All outputs are registered. Redirects land on pc_o one edge after sampling. Stalls hold PC and IF/ID independently.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             pc_stall_i,
  input  logic             stall_hold_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_pc4_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        redirect;

  assign pc_plus4 = pc_o + 32'd4;
  assign stall    = pc_stall_i | stall_hold_i;
  assign redirect = branch_i | jump_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      pc_o          <= PC_RESET;
      if_id_pc4_o   <= 32'h0;
      if_id_instr_o <= 32'h0;
      if_id_valid_o <= 1'b0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) state <= S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            // The stalled ID instruction re-issues any redirect once the stall clears.
            if (!pc_stall_i) pc_o <= pc_plus4;
            if (!stall_hold_i) begin
              if_id_pc4_o   <= pc_plus4;
              if_id_instr_o <= instr_i;
              if_id_valid_o <= 1'b1;
            end
            if (stall_cnt_o != CNT_MAX) stall_cnt_o <= stall_cnt_o + CNT_ONE;
          end else if (redirect) begin
            pc_o          <= branch_i ? branch_target_i : jump_target_i;
            if_id_pc4_o   <= 32'h0;
            if_id_instr_o <= 32'h0;
            if_id_valid_o <= 1'b0;
            if (flush_cnt_o != CNT_MAX) flush_cnt_o <= flush_cnt_o + CNT_ONE;
          end else begin
            pc_o          <= pc_plus4;
            if_id_pc4_o   <= pc_plus4;
            if_id_instr_o <= instr_i;
            if_id_valid_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed and randomized bench for if_stage against a cycle-level reference model.
module tb_if_stage;

  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i, pc_stall_i, stall_hold_i, branch_i, jump_i;
  logic [31:0]   branch_target_i, jump_target_i, instr_i;
  logic [31:0]   pc_o, if_id_pc4_o, if_id_instr_o;
  logic          if_id_valid_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_stall, m_flush;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign instr_i = imem(pc_o);

  if_stage #(.PC_RESET(32'h0000_0000), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .pc_stall_i(pc_stall_i), .stall_hold_i(stall_hold_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .instr_i(instr_i), .pc_o(pc_o), .if_id_pc4_o(if_id_pc4_o),
    .if_id_instr_o(if_id_instr_o), .if_id_valid_o(if_id_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pc"},    pc_o,                 m_pc);
    chk({tag, ":pc4"},   if_id_pc4_o,          m_pc4);
    chk({tag, ":instr"}, if_id_instr_o,        m_instr);
    chk({tag, ":valid"}, 32'(if_id_valid_o),   32'(m_valid));
    chk({tag, ":scnt"},  32'(stall_cnt_o),     32'(m_stall));
    chk({tag, ":fcnt"},  32'(flush_cnt_o),     32'(m_flush));
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_stall = 0; m_flush = 0;
  endtask

  // One clock edge: drive inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input logic st, input logic ps, input logic sh,
                      input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    logic [31:0] cur_pc;
    start_i = st; pc_stall_i = ps; stall_hold_i = sh;
    branch_i = br; branch_target_i = bt; jump_i = jp; jump_target_i = jt;
    cur_pc = m_pc;
    if (!m_run) begin
      if (st) m_run = 1;
    end else if (ps || sh) begin
      if (!sh) begin m_pc4 = cur_pc + 32'd4; m_instr = imem(cur_pc); m_valid = 1'b1; end
      if (!ps) m_pc = cur_pc + 32'd4;
      m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
    end else if (br || jp) begin
      m_pc = br ? bt : jt;
      m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_flush = (m_flush < MAXC) ? m_flush + 1 : MAXC;
    end else begin
      m_pc4 = cur_pc + 32'd4; m_instr = imem(cur_pc); m_valid = 1'b1;
      m_pc = cur_pc + 32'd4;
    end
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 0; pc_stall_i = 0; stall_hold_i = 0; branch_i = 0; jump_i = 0;
    branch_target_i = 32'h0; jump_target_i = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    rst_i = 1'b0;

    // Idle: inputs other than start are ignored
    step("idle0", 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    step("idle1", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h90);
    step("start", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
    run("fetch0");
    chk("first_instr", if_id_instr_o, 32'h2001_0005);
    chk("first_pc", pc_o, 32'h4);
    for (int i = 0; i < 3; i++) run("seq");

    // Full stall at 0x10 for two cycles
    chk("at_0x10", pc_o, 32'h10);
    step("stall_a", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step("stall_b", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_cnt2", 32'(stall_cnt_o), 32'd2);
    run("release");
    chk("after_stall", pc_o, 32'h14);
    run("seq18");

    // Branch at 0x18
    step("branch", 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("branch_pc", pc_o, 32'h40);
    run("post_branch");
    chk("post_branch_pc4", if_id_pc4_o, 32'h44);

    // Branch during stall is ignored, then taken once stall clears
    step("br_stalled", 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    step("br_release", 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("br_taken", pc_o, 32'h100);

    // Split stalls
    run("seq104");
    step("pc_stall_only", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    step("hold_only",     1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);

    // PC wrap and branch-over-jump priority
    step("jump_top", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    run("wrap");
    chk("wrap_pc", pc_o, 32'h0);
    step("br_and_jp", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0700);
    chk("br_wins", pc_o, 32'h500);

    // Randomized traffic, including unaligned targets and stray start pulses
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), $urandom(),
           ($urandom_range(0, 7) == 0), $urandom());
    end

    // Asynchronous reset between edges
    #3 rst_i = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    #1 rst_i = 1'b0;
    run("idle_after_rst");
    step("restart", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Saturation of both counters
    for (int i = 0; i < MAXC + 6; i++)
      step("sat_stall", 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < MAXC + 6; i++)
      step("sat_flush", 1'b0, 1'b0, 1'b0, 1'b1, $urandom(), 1'($urandom_range(0, 1)), $urandom());
    chk("stall_sat", 32'(stall_cnt_o), 32'(MAXC));
    chk("flush_sat", 32'(flush_cnt_o), 32'(MAXC));
    for (int i = 0; i < 20; i++)
      step("sat_mix", 1'b0, ($urandom_range(0, 1) == 0), 1'b0,
           1'b1, $urandom(), 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
